cfg_serial_tx: RTL



---
 rtl/cfg_serial_tx_if.sv | 14 +
 rtl/cfg_serial_tx.sv | 103 ++++++++++
 2 files changed

// File: rtl/cfg_serial_tx_if.sv
// cfg_serial_tx_if: request/status and serial-line bundle for cfg_serial_tx
interface cfg_serial_tx_if #(
  parameter int WIDTH = 58
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic             done;
  logic             sen;
  logic             sclk;
  logic             sdata;
  modport master (output start, data, input busy, done, sen, sclk, sdata);
  modport slave (input start, data, output busy, done, sen, sclk, sdata);
endinterface

// File: rtl/cfg_serial_tx.sv
// cfg_serial_tx: LSB-first sen/sclk/sdata configuration transmitter; CFG_TX_GUARD_EN adds a sen lead-in (HEAD) phase
module cfg_serial_tx #(
  parameter int WIDTH       = 58,
  parameter int HALF_PERIOD = 4
) (
  input logic            clk,
  input logic            rst,
  cfg_serial_tx_if.slave bus
);
  localparam int PW = $clog2(HALF_PERIOD);
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, HEAD, LOW, HIGH, TAIL, DONE} state_t;
  state_t           state_q, state_d;
  logic [PW-1:0]    ph_q, ph_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sen_q, sen_d;
  logic             sclk_q, sclk_d;
  logic             sdata_q, sdata_d;
  logic             ph_end;
  assign ph_end = ph_q == PW'(HALF_PERIOD - 1);
  // Next state, counters and shift register; outputs decoded from the next state so they leave a flop
  always_comb begin
    state_d = state_q;
    ph_d    = ph_end ? '0 : ph_q + PW'(1);
    bit_d   = bit_q;
    sr_d    = sr_q;
    case (state_q)
      IDLE: begin
        ph_d = '0;
        if (bus.start) begin
          sr_d    = bus.data;
          bit_d   = '0;
`ifdef CFG_TX_GUARD_EN
          state_d = HEAD;
`else
          state_d = LOW;
`endif
        end
      end
`ifdef CFG_TX_GUARD_EN
      HEAD: state_d = ph_end ? LOW : HEAD;
`endif
      LOW:  state_d = ph_end ? HIGH : LOW;
      HIGH: begin
        if (ph_end) begin
          if (bit_q == BW'(WIDTH - 1)) begin
            state_d = TAIL;
          end else begin
            state_d = LOW;
            sr_d    = sr_q >> 1;
            bit_d   = bit_q + BW'(1);
          end
        end
      end
      TAIL: state_d = ph_end ? DONE : TAIL;
      DONE: begin
        ph_d    = '0;
        state_d = IDLE;
      end
      default: begin
        ph_d    = '0;
        state_d = IDLE;
      end
    endcase
    sen_d   = state_d inside {HEAD, LOW, HIGH, TAIL};
    busy_d  = sen_d;
    done_d  = state_d == DONE;
    sclk_d  = state_d == HIGH;
    sdata_d = (state_d == LOW || state_d == HIGH) && sr_d[0];
  end
  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sen_q   <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sen_q   <= sen_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
    end
  end
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sen   = sen_q;
  assign bus.sclk  = sclk_q;
  assign bus.sdata = sdata_q;
endmodule
